// File: rtl/ssd_scan_decoder.sv
// Receive-side 7-segment scan decoder: samples a multiplexed segment bus, debounces each
// strobed pattern, decodes it to BCD and hands complete frames out over valid/ready.
module ssd_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    pattern_err,
   output logic                    overrun
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

   logic [6:0]              seg_s;
   logic [NUM_DIGITS-1:0]   dig_s;
   logic [CW-1:0]           cnt, cnt_next;
   logic                    same, acc, acc_next;
   logic                    legal, hit, err_set, frame_done;
   logic [3:0]              bcd;
   logic [3:0]              shadow [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   mask, mask_set;
   logic [4*NUM_DIGITS-1:0] frame;

   // A reload counts as reaching the threshold too, so STABLE_CYCLES=1 accepts every change once.
   always_comb begin
      same = (seg_in == seg_s) && (dig_sel == dig_s);
      if (!same)
         cnt_next = CW'(1);
      else if (cnt == CNT_MAX)
         cnt_next = cnt;
      else
         cnt_next = cnt + CW'(1);
      acc_next = (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX));
   end

   always_comb begin
      legal = 1'b1;
      bcd   = 4'd0;
      case (seg_s)
         7'b1111110: bcd = 4'd0;
         7'b0110000: bcd = 4'd1;
         7'b1101101: bcd = 4'd2;
         7'b1111001: bcd = 4'd3;
         7'b0110011: bcd = 4'd4;
         7'b1011011: bcd = 4'd5;
         7'b1011111: bcd = 4'd6;
         7'b1110000: bcd = 4'd7;
         7'b1111111: bcd = 4'd8;
         7'b1111011: bcd = 4'd9;
         default:    legal = 1'b0;
      endcase
   end

   // The accept flag lags the counter by one edge, so the still-registered sample is the stable one.
   always_comb begin
      hit        = acc && $onehot(dig_s);
      err_set    = hit && !legal;
      mask_set   = (hit && legal) ? dig_s : '0;
      frame_done = (mask == MASK_FULL);
      for (int i = 0; i < NUM_DIGITS; i++)
         frame[4*i +: 4] = shadow[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_s       <= '0;
         dig_s       <= '0;
         cnt         <= '0;
         acc         <= 1'b0;
         mask        <= '0;
         bcd_out     <= '0;
         out_valid   <= 1'b0;
         pattern_err <= 1'b0;
         overrun     <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++)
            shadow[i] <= 4'd0;
      end else begin
         seg_s <= seg_in;
         dig_s <= dig_sel;
         cnt   <= cnt_next;
         acc   <= acc_next;
         for (int i = 0; i < NUM_DIGITS; i++)
            if (mask_set[i])
               shadow[i] <= bcd;
         // A capture landing on the completion edge starts the next frame.
         mask <= (frame_done ? '0 : mask) | mask_set;
         if (err_set)
            pattern_err <= 1'b1;
         if (frame_done) begin
            if (!out_valid || out_ready) begin
               bcd_out   <= frame;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: expected frames are queued as scans are driven and
// popped by a monitor whenever the DUT hands a frame over.
module tb_ssd_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic [15:0] bcd_out;
   logic        out_valid;
   logic        out_ready;
   logic        pattern_err;
   logic        overrun;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int xfers  = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   ssd_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .bcd_out(bcd_out),
      .out_valid(out_valid), .out_ready(out_ready), .pattern_err(pattern_err), .overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] code(input int d);
      case (d)
         0: code = 7'b1111110;
         1: code = 7'b0110000;
         2: code = 7'b1101101;
         3: code = 7'b1111001;
         4: code = 7'b0110011;
         5: code = 7'b1011011;
         6: code = 7'b1011111;
         7: code = 7'b1110000;
         8: code = 7'b1111111;
         default: code = 7'b1111011;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic show(input int idx, input logic [6:0] seg, input int n);
      dig_sel = 4'(1 << idx);
      seg_in  = seg;
      tick(n);
   endtask

   task automatic idle(input int n);
      dig_sel = 4'b0000;
      seg_in  = 7'b0000000;
      tick(n);
   endtask

   // Scan digits 3..0 showing the four hex nibbles of val, high nibble on digit 3.
   task automatic scan(input logic [15:0] val);
      for (int i = 3; i >= 0; i--)
         show(i, code(int'(val[4*i +: 4])), 6);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         xfers++;
         total++;
         assert (exp_q.size() != 0) passed++;
         else begin
            fails++;
            $error("FAIL sb_underflow observed=%0h expected=queued_frame", bcd_out);
         end
         if (exp_q.size() != 0)
            chk("frame", bcd_out, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; seg_in = '0; dig_sel = '0; out_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_bcd", bcd_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_perr", pattern_err, 0);
      chk("rst_ovr", overrun, 0);

      // basic scan 3,2,1,0
      exp_q.push_back(16'h1234);
      scan(16'h1234);
      idle(3);
      chk("basic_xfers", xfers, 1);
      chk("basic_perr", pattern_err, 0);
      chk("basic_valid_low", out_valid, 0);

      // debounce: 3-cycle hold must not capture
      show(0, code(5), 3);
      idle(3);
      show(3, code(7), 6);
      show(2, code(8), 6);
      show(1, code(9), 6);
      chk("short_hold_valid", out_valid, 0);
      chk("short_hold_xfers", xfers, 1);
      exp_q.push_back(16'h7895);
      dig_sel = 4'b0001; seg_in = code(5);
      tick(5);
      chk("latency_edge5", out_valid, 0);
      tick(1);
      chk("latency_edge6", out_valid, 1);
      tick(18);
      // long hold accepted once: refilling 3..1 must not complete a frame
      show(3, code(1), 6);
      show(2, code(1), 6);
      show(1, code(1), 6);
      idle(3);
      chk("single_accept_xfers", xfers, 2);
      chk("single_accept_valid", out_valid, 0);
      exp_q.push_back(16'h1110);
      show(0, code(0), 6);
      idle(3);
      chk("any_order_xfers", xfers, 3);

      // illegal pattern and multi-hot strobe
      show(3, code(2), 6);
      show(2, code(3), 6);
      show(1, code(4), 6);
      show(0, 7'b0000001, 6);
      chk("illegal_perr", pattern_err, 1);
      chk("illegal_no_frame", out_valid, 0);
      dig_sel = 4'b0011; seg_in = code(8);
      tick(6);
      chk("multihot_no_frame", out_valid, 0);
      exp_q.push_back(16'h2341);
      show(0, code(1), 6);
      idle(3);
      chk("after_err_xfers", xfers, 4);

      // accept coincides with next completion
      out_ready = 1'b0;
      exp_q.push_back(16'h4321);
      scan(16'h4321);
      chk("pend_valid", out_valid, 1);
      exp_q.push_back(16'h8765);
      show(3, code(8), 6);
      show(2, code(7), 6);
      show(1, code(6), 6);
      dig_sel = 4'b0001; seg_in = code(5);
      tick(5);
      chk("pend_bcd_held", bcd_out, 16'h4321);
      out_ready = 1'b1;
      tick(1);
      chk("simul_valid", out_valid, 1);
      chk("simul_bcd", bcd_out, 16'h8765);
      chk("simul_ovr", overrun, 0);
      idle(3);
      chk("simul_drained", out_valid, 0);

      // overrun with pending output
      out_ready = 1'b0;
      exp_q.push_back(16'h9876);
      scan(16'h9876);
      scan(16'h0000);
      idle(2);
      chk("ovr_bcd_kept", bcd_out, 16'h9876);
      chk("ovr_valid", out_valid, 1);
      chk("ovr_flag", overrun, 1);
      out_ready = 1'b1;
      tick(1);
      chk("ovr_accept_clears", out_valid, 0);
      chk("ovr_sticky", overrun, 1);
      idle(2);

      // reset mid-frame
      show(3, code(1), 6);
      show(2, code(2), 6);
      show(1, code(3), 6);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst2_bcd", bcd_out, 0);
      chk("rst2_valid", out_valid, 0);
      chk("rst2_perr", pattern_err, 0);
      chk("rst2_ovr", overrun, 0);
      show(3, code(9), 6);
      idle(4);
      chk("rst2_no_frame", out_valid, 0);
      chk("total_xfers", xfers, 7);
      chk("sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
